// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote around each mid-bit, decided one cycle later.
module simple_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

`ifdef RX_MAJORITY_VOTE_EN
    localparam int START_LAST = CLKS_PER_BIT / 2;
`else
    localparam int START_LAST = CLKS_PER_BIT / 2 - 1;
`endif

    localparam logic [CW-1:0] START_END = CW'(START_LAST);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          sync1_q, rx_s_q;
    logic          sample;

`ifdef RX_MAJORITY_VOTE_EN
    // rx_s history: rx_d1_q is the mid value when the decision is taken at mid+1
    logic rx_d1_q, rx_d2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d1_q <= 1'b1;
            rx_d2_q <= 1'b1;
        end else begin
            rx_d1_q <= rx_s_q;
            rx_d2_q <= rx_d1_q;
        end
    end

    assign sample = (rx_s_q & rx_d1_q) | (rx_s_q & rx_d2_q) | (rx_d1_q & rx_d2_q);
`else
    assign sample = rx_s_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= line;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == START_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // a start bit that has vanished by mid-bit is treated as noise
                    state_d = sample ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = sample;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (sample) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_simple_uart_rx.sv
// Directed testbench for simple_uart_rx (CLKS_PER_BIT = 16).
// Expectations follow RX_MAJORITY_VOTE_EN when it is defined for the build.
module tb_simple_uart_rx;

    localparam int CPB = 16;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif
    // start edge -> valid: 2 sync + half bit + 9 bits (+1 with voting)
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + VOTE;

    logic       clk;
    logic       rst;
    logic       line;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;

    int testCount = 0;
    int failCount = 0;
    int cycle = 0;
    int startEdge;
    int nValid;
    int nErr;

    logic [7:0] validData[$];
    int         validCycles[$];
    int         errCycles[$];
    logic       prevValid = 1'b0;
    logic       prevErr = 1'b0;
    logic       longPulse = 1'b0;
    logic       bothSeen = 1'b0;

    simple_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .line      (line),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record every pulse on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (valid) begin
            validData.push_back(data);
            validCycles.push_back(cycle);
        end
        if (frame_err) errCycles.push_back(cycle);
        if ((valid && prevValid) || (frame_err && prevErr)) longPulse = 1'b1;
        if (valid && frame_err) bothSeen = 1'b1;
        prevValid = valid;
        prevErr   = frame_err;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full frame; line is left at the stop-bit level
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        line = 1'b0;
        startEdge = cycle + 1;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            waitCycles(CPB);
        end
        line = stopBit;
        waitCycles(CPB);
    endtask

    initial begin
        rst  = 1'b1;
        line = 1'b1;
        waitCycles(3);
        checkOutput("reset_data", {24'd0, data}, 32'h00);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        waitCycles(5);

        // single 0x01 frame
        nValid = validData.size();
        applyStimulus(8'h01, 1'b1);
        waitCycles(4);
        checkOutput("f01_count", validData.size() - nValid, 32'd1);
        checkOutput("f01_data", {24'd0, validData[nValid]}, 32'h01);
        checkOutput("f01_latency", validCycles[nValid] - startEdge, LATENCY);
        checkOutput("f01_ferr", errCycles.size(), 32'd0);
        checkOutput("f01_busy_after", {31'd0, busy}, 32'd0);

        // back-to-back 0xA5, 0x5A
        nValid = validData.size();
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(4);
        checkOutput("b2b_count", validData.size() - nValid, 32'd2);
        checkOutput("b2b_first", {24'd0, validData[nValid]}, 32'hA5);
        checkOutput("b2b_second", {24'd0, validData[nValid+1]}, 32'h5A);
        checkOutput("b2b_spacing", validCycles[nValid+1] - validCycles[nValid], 10 * CPB);
        checkOutput("b2b_data_out", {24'd0, data}, 32'h5A);

        // 4-cycle low glitch while idle is a false start
        nValid = validData.size();
        nErr   = errCycles.size();
        line = 1'b0;
        waitCycles(4);
        line = 1'b1;
        checkOutput("false_busy_high", {31'd0, busy}, 32'd1);
        waitCycles(8);
        checkOutput("false_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("false_no_valid", validData.size() - nValid, 32'd0);
        checkOutput("false_no_ferr", errCycles.size() - nErr, 32'd0);

        // framing error after a good 0x01, line held low, then recovery with 0x77
        applyStimulus(8'h01, 1'b1);
        waitCycles(4);
        nValid = validData.size();
        nErr   = errCycles.size();
        applyStimulus(8'h3C, 1'b0);
        waitCycles(40);
        checkOutput("ferr_count", errCycles.size() - nErr, 32'd1);
        checkOutput("ferr_latency", errCycles[nErr] - startEdge, LATENCY);
        checkOutput("ferr_no_valid", validData.size() - nValid, 32'd0);
        checkOutput("ferr_data_hold", {24'd0, data}, 32'h01);
        checkOutput("ferr_busy_low_line", {31'd0, busy}, 32'd1);
        line = 1'b1;
        waitCycles(4);
        checkOutput("ferr_busy_released", {31'd0, busy}, 32'd0);
        applyStimulus(8'h77, 1'b1);
        waitCycles(4);
        checkOutput("ferr_next_count", validData.size() - nValid, 32'd1);
        checkOutput("ferr_next_data", {24'd0, data}, 32'h77);

        // reset pulse during bit 4 of 0xFF
        nValid = validData.size();
        nErr   = errCycles.size();
        line = 1'b0;
        waitCycles(CPB);
        line = 1'b1;
        waitCycles(4 * CPB + CPB / 2);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst_mid_data", {24'd0, data}, 32'h00);
        checkOutput("rst_mid_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        waitCycles(CPB / 2 - 1 + 4 * CPB);
        checkOutput("rst_no_valid", validData.size() - nValid, 32'd0);
        checkOutput("rst_no_ferr", errCycles.size() - nErr, 32'd0);
        applyStimulus(8'h42, 1'b1);
        waitCycles(4);
        checkOutput("rst_next_data", {24'd0, data}, 32'h42);

        // 0x00 with a one-cycle high glitch at the bit-2 sample point
        nValid = validData.size();
        line = 1'b0;
        waitCycles(CPB / 2 + 3 * CPB);
        line = 1'b1;
        waitCycles(1);
        line = 1'b0;
        waitCycles(6 * CPB - CPB / 2 - 1);
        line = 1'b1;
        waitCycles(CPB + 4);
        checkOutput("glitch_count", validData.size() - nValid, 32'd1);
        checkOutput("glitch_data", {24'd0, data}, (VOTE != 0) ? 32'h00 : 32'h04);

        checkOutput("never_both", {31'd0, bothSeen}, 32'd0);
        checkOutput("single_cycle_pulses", {31'd0, longPulse}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
